// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: hazard inputs from the pipeline and stall/flush controls back to it
interface pipe_hazard_if #(parameter int CNT_W = 16);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [4:0]       ex_rw;
  logic             ex_regwrite;
  logic             ex_memtoreg;
  logic             ex_br_taken;
  logic             ex_jmp;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_flush;
  logic [1:0]       state;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_rw, ex_regwrite, ex_memtoreg,
           ex_br_taken, ex_jmp, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_flush,
           state, mem_err, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rw, ex_regwrite, ex_memtoreg,
           ex_br_taken, ex_jmp, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_flush,
           state, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for a 5-stage MIPS pipeline with memory-wait timeout
module pipe_hazard_ctrl #(
  parameter int HOLD_CYC    = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst,
  pipe_hazard_if.slave  hz_io
);
  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_WAIT = 2'b10;
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  logic [1:0]       state_q, state_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             hold, mem_stall, freeze, timeout, br, lu;
  always_comb begin
    hold        = !rst || state_q == S_HOLD;
    mem_stall   = !hold && hz_io.mem_req && !hz_io.mem_ready;
    freeze      = mem_stall && wait_cnt_q != WW'(MEM_TIMEOUT);
    timeout     = mem_stall && !freeze;
    br          = !hold && !freeze && (hz_io.ex_br_taken || hz_io.ex_jmp);
    lu          = !hold && !freeze && !br && hz_io.ex_memtoreg && hz_io.ex_regwrite &&
                  hz_io.ex_rw != 5'd0 &&
                  ((hz_io.id_use_rs && hz_io.id_rs == hz_io.ex_rw) ||
                   (hz_io.id_use_rt && hz_io.id_rt == hz_io.ex_rw));
    hz_io.pc_en       = !hold && !freeze && (br || !lu);
    hz_io.ifid_en     = !hold && !freeze && (br || !lu);
    hz_io.ifid_flush  = hold || br;
    hz_io.idex_flush  = hold || br || lu;
    hz_io.exmem_en    = hold || !freeze;
    hz_io.memwb_flush = hold || freeze;
    hz_io.state       = !rst ? S_HOLD : state_q;
    hz_io.mem_err     = mem_err_q;
    hz_io.stall_cnt   = stall_cnt_q;
    hz_io.flush_cnt   = flush_cnt_q;
    state_d     = state_q == S_HOLD ? (hold_cnt_q == HW'(HOLD_CYC - 1) ? S_RUN : S_HOLD)
                                    : (freeze ? S_WAIT : S_RUN);
    hold_cnt_d  = state_q == S_HOLD ? hold_cnt_q + 1'b1 : hold_cnt_q;
    wait_cnt_d  = freeze ? wait_cnt_q + 1'b1 : '0;
    mem_err_d   = mem_err_q || timeout;
    stall_cnt_d = (freeze || lu) && stall_cnt_q != '1 ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = br && flush_cnt_q != '1 ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_HOLD;
      hold_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of reset drain, load-use, branch flush, memory freeze/timeout
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_run = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  pipe_hazard_if #(.CNT_W(16)) a_if ();
  pipe_hazard_if #(.CNT_W(2))  b_if ();
  assign b_if.id_rs       = a_if.id_rs;
  assign b_if.id_rt       = a_if.id_rt;
  assign b_if.id_use_rs   = a_if.id_use_rs;
  assign b_if.id_use_rt   = a_if.id_use_rt;
  assign b_if.ex_rw       = a_if.ex_rw;
  assign b_if.ex_regwrite = a_if.ex_regwrite;
  assign b_if.ex_memtoreg = a_if.ex_memtoreg;
  assign b_if.ex_br_taken = a_if.ex_br_taken;
  assign b_if.ex_jmp      = a_if.ex_jmp;
  assign b_if.mem_req     = a_if.mem_req;
  assign b_if.mem_ready   = a_if.mem_ready;
  pipe_hazard_ctrl #(.HOLD_CYC(4), .MEM_TIMEOUT(16), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .hz_io(a_if.slave));
  pipe_hazard_ctrl #(.HOLD_CYC(4), .MEM_TIMEOUT(16), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .hz_io(b_if.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    a_if.id_rs = 0; a_if.id_rt = 0; a_if.id_use_rs = 0; a_if.id_use_rt = 0;
    a_if.ex_rw = 0; a_if.ex_regwrite = 0; a_if.ex_memtoreg = 0;
    a_if.ex_br_taken = 0; a_if.ex_jmp = 0; a_if.mem_req = 0; a_if.mem_ready = 0;
  endtask
  task automatic chk_hold(input string tag);
    chk({tag, "_pc"}, a_if.pc_en, 0);
    chk({tag, "_ifid_en"}, a_if.ifid_en, 0);
    chk({tag, "_ifid_fl"}, a_if.ifid_flush, 1);
    chk({tag, "_idex_fl"}, a_if.idex_flush, 1);
    chk({tag, "_exmem"}, a_if.exmem_en, 1);
    chk({tag, "_memwb_fl"}, a_if.memwb_flush, 1);
    chk({tag, "_state"}, a_if.state, 0);
  endtask
  initial begin
    rst = 1'b0;
    clr();
    step();
    step();
    chk_hold("rst");
    chk("rst_stall", a_if.stall_cnt, 0);
    chk("rst_flush", a_if.flush_cnt, 0);
    chk("rst_err", a_if.mem_err, 0);
    rst = 1'b1;
    a_if.ex_br_taken = 1;
    a_if.mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_hold("hold");
      step();
    end
    clr();
    #1;
    chk("run_state", a_if.state, 1);
    chk("run_pc", a_if.pc_en, 1);
    chk("run_ifid_fl", a_if.ifid_flush, 0);
    chk("run_idex_fl", a_if.idex_flush, 0);
    chk("hold_ignored_flush", a_if.flush_cnt, 0);
    chk("hold_ignored_stall", a_if.stall_cnt, 0);
    a_if.ex_memtoreg = 1; a_if.ex_regwrite = 1; a_if.ex_rw = 5; a_if.id_rs = 5; a_if.id_use_rs = 1;
    #1;
    chk("lu_pc", a_if.pc_en, 0);
    chk("lu_ifid_en", a_if.ifid_en, 0);
    chk("lu_idex_fl", a_if.idex_flush, 1);
    chk("lu_ifid_fl", a_if.ifid_flush, 0);
    chk("lu_exmem", a_if.exmem_en, 1);
    step();
    clr();
    #1;
    chk("lu_stall_cnt", a_if.stall_cnt, 1);
    chk("lu_one_cycle", a_if.pc_en, 1);
    a_if.ex_memtoreg = 1; a_if.ex_regwrite = 1; a_if.ex_rw = 9; a_if.id_rt = 9; a_if.id_use_rt = 1;
    #1;
    chk("lu_rt_pc", a_if.pc_en, 0);
    a_if.id_use_rt = 0;
    #1;
    chk("lu_rt_unused", a_if.pc_en, 1);
    a_if.ex_rw = 0; a_if.id_rs = 0; a_if.id_use_rs = 1;
    #1;
    chk("r0_pc", a_if.pc_en, 1);
    chk("r0_idex_fl", a_if.idex_flush, 0);
    step();
    chk("r0_stall_cnt", a_if.stall_cnt, 1);
    a_if.ex_rw = 5; a_if.id_rs = 5; a_if.ex_br_taken = 1;
    #1;
    chk("br_pc", a_if.pc_en, 1);
    chk("br_ifid_fl", a_if.ifid_flush, 1);
    chk("br_idex_fl", a_if.idex_flush, 1);
    step();
    clr();
    a_if.ex_jmp = 1;
    #1;
    chk("br_flush_cnt", a_if.flush_cnt, 1);
    chk("br_stall_cnt", a_if.stall_cnt, 1);
    chk("jmp_ifid_fl", a_if.ifid_flush, 1);
    step();
    clr();
    a_if.mem_req = 1; a_if.ex_br_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_pc", a_if.pc_en, 0);
      chk("frz_exmem", a_if.exmem_en, 0);
      chk("frz_memwb_fl", a_if.memwb_flush, 1);
      chk("frz_ifid_fl", a_if.ifid_flush, 0);
      chk("frz_idex_fl", a_if.idex_flush, 0);
      step();
      chk("frz_state", a_if.state, 2);
    end
    a_if.mem_ready = 1;
    #1;
    chk("rdy_pc", a_if.pc_en, 1);
    chk("rdy_exmem", a_if.exmem_en, 1);
    chk("rdy_memwb_fl", a_if.memwb_flush, 0);
    chk("rdy_br_fl", a_if.ifid_flush, 1);
    step();
    clr();
    #1;
    chk("rdy_state", a_if.state, 1);
    chk("rdy_stall_cnt", a_if.stall_cnt, 4);
    chk("rdy_flush_cnt", a_if.flush_cnt, 3);
    chk("rdy_err", a_if.mem_err, 0);
    a_if.mem_req = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("to_pc_%0d", i), a_if.pc_en, (i == 16) ? 1 : 0);
      chk($sformatf("to_memwb_%0d", i), a_if.memwb_flush, (i == 16) ? 0 : 1);
      step();
      chk($sformatf("to_err_%0d", i), a_if.mem_err, (i >= 16) ? 1 : 0);
    end
    chk("to_state", a_if.state, 2);
    chk("to_stall_cnt", a_if.stall_cnt, 23);
    clr();
    step();
    chk("err_sticky", a_if.mem_err, 1);
    chk("err_state", a_if.state, 1);
    a_if.ex_br_taken = 1;
    step();
    step();
    clr();
    #1;
    chk("sat_flush_a", a_if.flush_cnt, 5);
    chk("sat_flush_b", b_if.flush_cnt, 3);
    chk("sat_stall_b", b_if.stall_cnt, 3);
    a_if.mem_req = 1;
    step();
    chk("mid_state", a_if.state, 2);
    rst = 1'b0;
    #1;
    chk_hold("mid_rst");
    step();
    chk("mid_err", a_if.mem_err, 0);
    chk("mid_stall", a_if.stall_cnt, 0);
    chk("mid_flush", a_if.flush_cnt, 0);
    chk("mid_flush_b", b_if.flush_cnt, 0);
    rst = 1'b1;
    #1;
    chk_hold("post_rst");
    step();
    chk("post_state", a_if.state, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
